// File: rtl/mul32_seq.sv
// Sequential unsigned 32x32->64 shift-add multiplier that borrows a shared
// external 32-bit adder each iteration and accumulates into a 64-bit register.
module mul32_seq #(
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        START,
   input  logic [31:0] MCAND,
   input  logic [31:0] MPLIER,
   output logic        READY,
   output logic        BUSY,
   output logic        DONE,
   output logic [63:0] PROD,
   output logic [31:0] ADD_A,
   output logic [31:0] ADD_B,
   output logic        ADD_CIN,
   input  logic [31:0] ADD_SUM,
   input  logic        ADD_COUT
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] m_q, q_q, acc_hi_q, acc_lo_q;
   logic [5:0]  cnt_q;
   logic [63:0] prod_q;

   logic        exit_now, last_iter;
   logic [31:0] hi_nx, lo_nx;
   logic [6:0]  exit_sh;
   logic [63:0] exit_prod;

   assign exit_now  = EARLY_EXIT && (q_q == '0);
   assign last_iter = (cnt_q == 6'd31);

   // Carry-out becomes the new top bit so the 33-bit sum is never truncated.
   assign hi_nx = {ADD_COUT, ADD_SUM[31:1]};
   assign lo_nx = {ADD_SUM[0], acc_lo_q[31:1]};

   // After CNT iterations the partial product sits 32-CNT bits too high.
   assign exit_sh   = 7'd32 - {1'b0, cnt_q};
   assign exit_prod = {acc_hi_q, acc_lo_q} >> exit_sh;

   assign PROD = prod_q;

   always_comb begin
      state_d = state_q;
      READY   = 1'b0;
      BUSY    = 1'b0;
      DONE    = 1'b0;
      ADD_A   = '0;
      ADD_B   = '0;
      ADD_CIN = 1'b0;
      case (state_q)
         S_IDLE: begin
            READY = 1'b1;
            if (START) state_d = S_RUN;
         end
         S_RUN: begin
            BUSY  = 1'b1;
            ADD_A = acc_hi_q;
            ADD_B = q_q[0] ? m_q : '0;
            if (exit_now || last_iter) state_d = S_DONE;
         end
         S_DONE: begin
            BUSY    = 1'b1;
            DONE    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q  <= S_IDLE;
         m_q      <= '0;
         q_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  m_q      <= MCAND;
                  q_q      <= MPLIER;
                  acc_hi_q <= '0;
                  acc_lo_q <= '0;
                  cnt_q    <= '0;
               end
            end
            S_RUN: begin
               if (exit_now) begin
                  prod_q <= exit_prod;
               end else begin
                  acc_hi_q <= hi_nx;
                  acc_lo_q <= lo_nx;
                  q_q      <= q_q >> 1;
                  cnt_q    <= cnt_q + 6'd1;
                  if (last_iter) prod_q <= {hi_nx, lo_nx};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul32_seq.sv
// Scoreboard bench for mul32_seq: one instance per EARLY_EXIT setting, each
// with its own adder model and a monitor checking product, latency and handshake.
module tb_mul32_seq;

   typedef struct {
      logic [63:0] prod;
      int          lat;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic [31:0] MCAND = '0;
   logic [31:0] MPLIER = '0;
   int          tests = 0;
   int          fails = 0;
   int          edges = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) edges++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input bit ee, input logic [31:0] mp);
      int k = 0;
      if (!ee) return 32;
      for (int b = 0; b < 32; b++) if (mp[b]) k = b + 1;
      return (k + 1 > 32) ? 32 : k + 1;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic        start = 1'b0;
      logic        ready, busy, done, add_cin, add_cout;
      logic [63:0] prod;
      logic [31:0] add_a, add_b, add_sum;
      exp_t        q[$];
      exp_t        e_cur;
      bit          infl = 1'b0;
      bit          prev_done = 1'b0;
      logic [63:0] prev_prod = '0;
      int          acc_edge = 0;
      int          done_edge = 0;
      int          n_done = 0;

      assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

      mul32_seq #(.EARLY_EXIT(g == 1)) u_dut (
         .CLK(CLK), .RSTN(RSTN), .START(start), .MCAND(MCAND), .MPLIER(MPLIER),
         .READY(ready), .BUSY(busy), .DONE(done), .PROD(prod),
         .ADD_A(add_a), .ADD_B(add_b), .ADD_CIN(add_cin),
         .ADD_SUM(add_sum), .ADD_COUT(add_cout)
      );

      always @(negedge CLK) begin
         if (!RSTN) begin
            infl      = 1'b0;
            prev_done = 1'b0;
            prev_prod = '0;
            q.delete();
         end else begin
            chk($sformatf("ee%0d_cin", g), 64'(add_cin), 64'd0);
            chk($sformatf("ee%0d_ready_vs_busy", g), 64'(ready ^ busy), 64'd1);
            if (ready || done)
               chk($sformatf("ee%0d_adder_idle", g), {add_a, add_b}, 64'd0);
            if (infl)
               chk($sformatf("ee%0d_inflight_rdy_bsy", g), {62'd0, ready, busy}, 64'd1);
            if (done) begin
               chk($sformatf("ee%0d_done_pulse", g), 64'(prev_done), 64'd0);
               chk($sformatf("ee%0d_spurious_done", g), 64'(infl && q.size() > 0), 64'd1);
               if (infl && q.size() > 0) begin
                  e_cur = q.pop_front();
                  chk($sformatf("ee%0d_prod", g), prod, e_cur.prod);
                  chk($sformatf("ee%0d_latency", g), 64'(edges - acc_edge), 64'(e_cur.lat));
               end
               infl      = 1'b0;
               done_edge = edges;
               n_done++;
            end else if (prod !== prev_prod) begin
               chk($sformatf("ee%0d_prod_stable", g), prod, prev_prod);
            end
            if (ready && start) begin
               infl     = 1'b1;
               acc_edge = edges + 1;
            end
            prev_done = done;
            prev_prod = prod;
         end
      end
   end

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge CLK); #1;
         ok = !g_dut[0].infl && !g_dut[1].infl && g_dut[0].ready && g_dut[1].ready;
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL idle_timeout: got busy after 200 cycles, expected idle");
      end
   endtask

   task automatic push(input int which, input logic [63:0] p, input logic [31:0] mp);
      exp_t e;
      e.prod = p;
      e.lat  = exp_lat(which == 1, mp);
      if (which == 0) g_dut[0].q.push_back(e);
      else            g_dut[1].q.push_back(e);
   endtask

   task automatic issue(input bit en0, input bit en1, input logic [31:0] mc,
                        input logic [31:0] mp, input logic [63:0] p);
      wait_idle();
      @(posedge CLK); #1;
      MCAND  = mc;
      MPLIER = mp;
      g_dut[0].start = en0;
      g_dut[1].start = en1;
      if (en0) push(0, p, mp);
      if (en1) push(1, p, mp);
      @(posedge CLK); #1;
      g_dut[0].start = 1'b0;
      g_dut[1].start = 1'b0;
   endtask

   localparam int ND = 11;
   logic [31:0] dmc [ND] = '{32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678,
                             32'd1, 32'hFFFF_FFFF, 32'd2, 32'h0001_0000, 32'd0, 32'd7};
   logic [31:0] dmp [ND] = '{32'd5, 32'hFFFF_FFFF, 32'd0, 32'd4, 32'h9ABC_DEF0,
                             32'd1, 32'd1, 32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF,
                             32'h4000_0000};
   logic [63:0] dpr [ND] = '{64'hF, 64'hFFFF_FFFE_0000_0001, 64'd0, 64'h0000_0002_0000_0000,
                             64'h0B00_EA4E_242D_2080, 64'd1, 64'h0000_0000_FFFF_FFFF,
                             64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd0,
                             64'h0000_0001_C000_0000};

   initial begin
      #600000;
      $display("FAIL watchdog: got no finish by 600000, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, d;
      bit ok;
      logic [31:0] mc, mp;

      repeat (3) @(posedge CLK);
      #1 RSTN = 1'b1;
      @(negedge CLK); #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst%0d_ready", i), 64'(i == 0 ? g_dut[0].ready : g_dut[1].ready), 64'd1);
         chk($sformatf("rst%0d_busy", i),  64'(i == 0 ? g_dut[0].busy  : g_dut[1].busy),  64'd0);
         chk($sformatf("rst%0d_done", i),  64'(i == 0 ? g_dut[0].done  : g_dut[1].done),  64'd0);
         chk($sformatf("rst%0d_prod", i),  i == 0 ? g_dut[0].prod : g_dut[1].prod, 64'd0);
      end

      for (int i = 0; i < ND; i++) issue(1'b1, 1'b1, dmc[i], dmp[i], dpr[i]);

      // START held through a whole run with operands changing mid-run
      wait_idle();
      @(posedge CLK); #1;
      MCAND = 32'h1234_5678; MPLIER = 32'h9ABC_DEF0;
      g_dut[1].start = 1'b1;
      push(1, 64'h0B00_EA4E_242D_2080, MPLIER);
      base = g_dut[1].n_done;
      @(posedge CLK); #1;
      MCAND = 32'd3; MPLIER = 32'd5;
      push(1, 64'hF, MPLIER);
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge CLK); #1;
         ok = (g_dut[1].n_done != base);
      end
      chk("t4_first_done_seen", 64'(ok), 64'd1);
      d = g_dut[1].done_edge;
      @(negedge CLK); #1;
      chk("t4_reaccept_edge", 64'(g_dut[1].acc_edge), 64'(d + 2));
      @(posedge CLK); #1;
      g_dut[1].start = 1'b0;

      // reset at iteration 10 of a full-length run
      issue(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080);
      repeat (9) @(posedge CLK);
      #1 RSTN = 1'b0;
      @(posedge CLK); #1 RSTN = 1'b1;
      @(negedge CLK); #1;
      chk("midrst_ready0", 64'(g_dut[0].ready), 64'd1);
      chk("midrst_ready1", 64'(g_dut[1].ready), 64'd1);
      chk("midrst_prod0", g_dut[0].prod, 64'd0);
      chk("midrst_prod1", g_dut[1].prod, 64'd0);
      chk("midrst_done1", 64'(g_dut[1].done), 64'd0);
      repeat (40) @(negedge CLK);
      issue(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080);

      for (int i = 0; i < 300; i++) begin
         mc = $urandom;
         mp = $urandom >> $urandom_range(0, 31);
         issue(1'b1, 1'b1, mc, mp, 64'(mc) * 64'(mp));
      end

      wait_idle();
      chk("sb_empty0", 64'(g_dut[0].q.size()), 64'd0);
      chk("sb_empty1", 64'(g_dut[1].q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
